// File: rtl/ntt_host_ctrl_if.sv
// Host-side bundle for ntt_host_ctrl: command handshake, coefficient input
// stream and result output stream.
interface ntt_host_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;

    modport master (
        output cmd_valid, cmd_mode, s_valid, s_data, m_ready,
        input  cmd_ready, s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  cmd_valid, cmd_mode, s_valid, s_data, m_ready,
        output cmd_ready, s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ntt_host_ctrl.sv
// Job sequencer around an NTT core: load N words into BRAM, kick the core,
// wait for its done pulse under a watchdog, then stream the BRAM back out.
module ntt_host_ctrl #(
    parameter int N         = 256,
    parameter int TIMEOUT   = 20000,
    parameter int START_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ntt_host_ctrl_if.slave    bus,
    output logic [7:0]        o_bram_addr,
    output logic              o_bram_we,
    output logic [15:0]       o_bram_din,
    input  logic [15:0]       i_bram_dout,
    output logic              o_core_start,
    output logic              o_core_mode,
    input  logic              i_core_done,
    output logic              o_job_done,
    output logic              o_err_timeout
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    localparam logic [7:0]  LAST_IDX  = 8'(N - 1);
    localparam logic [15:0] WDOG_LIM  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  START_LIM = 8'(START_LEN - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_mode;
    logic [7:0]  r_start_cnt;
    logic [15:0] r_wdog;
    logic        r_err;
    logic [7:0]  r_rd_addr;
    logic        r_rd_done;
    logic        r_rd_pend;
    logic        r_rd_pend_last;
    logic [15:0] r_fifo_data [2];
    logic [1:0]  r_fifo_last;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_fifo_cnt;

    logic        w_m_hs;
    logic        w_m_last;
    logic [2:0]  w_occ;
    logic        w_rd_issue;
    logic        w_drain_go;

    assign w_m_hs     = (r_fifo_cnt != 2'd0) && bus.m_ready;
    assign w_m_last   = r_fifo_last[r_rd_ptr] && (r_fifo_cnt != 2'd0);
    // Count the word leaving this cycle so a full-rate stream keeps one read in flight.
    assign w_occ      = {1'b0, r_fifo_cnt} + {2'b00, r_rd_pend} - {2'b00, w_m_hs};
    assign w_rd_issue = (r_state == S_DRAIN) && !r_rd_done && (w_occ < 3'd2);
    assign w_drain_go = (r_state == S_WAIT_LO) && !i_core_done;

    // Job sequencing, word counter, start pulse timer and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_mode      <= 1'b0;
            r_start_cnt <= 8'd0;
            r_wdog      <= 16'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_mode  <= bus.cmd_mode;
                        r_cnt   <= 8'd0;
                        r_err   <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.s_valid) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == LAST_IDX) begin
                            r_start_cnt <= 8'd0;
                            r_state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (r_start_cnt == START_LIM) begin
                        r_wdog  <= 16'd0;
                        r_state <= S_WAIT_HI;
                    end else begin
                        r_start_cnt <= r_start_cnt + 8'd1;
                    end
                end
                S_WAIT_HI, S_WAIT_LO: begin
                    // Watchdog wins over a done edge arriving on the same cycle.
                    if (r_wdog == WDOG_LIM) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                        if ((r_state == S_WAIT_HI) && i_core_done) begin
                            r_state <= S_WAIT_LO;
                        end else if (w_drain_go) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_m_hs && w_m_last) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // BRAM read issue; data arrives one cycle after the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr      <= 8'd0;
            r_rd_done      <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
        end else if (w_drain_go) begin
            r_rd_addr      <= 8'd0;
            r_rd_done      <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
        end else begin
            r_rd_pend      <= w_rd_issue;
            r_rd_pend_last <= (r_rd_addr == LAST_IDX);
            if (w_rd_issue) begin
                r_rd_addr <= r_rd_addr + 8'd1;
                if (r_rd_addr == LAST_IDX) begin
                    r_rd_done <= 1'b1;
                end
            end
        end
    end

    // Two-entry output FIFO holding read data and the last-word flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_data[0] <= 16'h0000;
            r_fifo_data[1] <= 16'h0000;
            r_fifo_last    <= 2'b00;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_fifo_cnt     <= 2'd0;
        end else begin
            if (r_rd_pend) begin
                r_fifo_data[r_wr_ptr] <= i_bram_dout;
                r_fifo_last[r_wr_ptr] <= r_rd_pend_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_m_hs) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_rd_pend} - {1'b0, w_m_hs};
        end
    end

    // Output decode from state and FIFO registers.
    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.s_ready   = (r_state == S_LOAD);
        bus.m_valid   = (r_fifo_cnt != 2'd0);
        bus.m_data    = r_fifo_data[r_rd_ptr];
        bus.m_last    = w_m_last;
        o_bram_we     = (r_state == S_LOAD) && bus.s_valid;
        o_bram_din    = 16'h0000;
        o_bram_addr   = 8'd0;
        if (r_state == S_LOAD) begin
            o_bram_din  = bus.s_data;
            o_bram_addr = r_cnt;
        end else if (r_state == S_DRAIN) begin
            o_bram_addr = r_rd_addr;
        end else begin
            o_bram_addr = 8'd0;
        end
        o_core_start  = (r_state == S_START);
        o_core_mode   = r_mode;
        o_job_done    = (r_state == S_FIN);
        o_err_timeout = r_err;
    end
endmodule
